mem_wb_stage: RTL and testbench

Memory-access and writeback end of the pipelined RISC-V core. Consumes the core's memory-stage outputs (ALUResultM, WriteDataM, MemWriteM, ResultSrcM, RegWriteM, RdM, PCPlus4M) and performs the word data-memory access. Registers the result into the writeback stage and returns RegWriteW, RdW and ResultW to the core, closing the M→W loop that the register file and hazard unit depend on.

---
 rtl/mem_wb_stage.sv | 130 +++++++++++++
 tb/tb_mem_wb_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: word data RAM, M->W pipeline register, result mux.
// Optional macro MMIO_EN adds a memory-mapped output port at MMIO_ADDR.
module mem_wb_stage #(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [1:0]  ResultSrcM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdM,
  input  logic        MemWriteM,
`ifdef MMIO_EN
  output logic [31:0] mmio_data,
  output logic        mmio_valid,
`endif
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   ram_q [MEM_WORDS];
  logic [AW-1:0] idx_s;
  logic          ram_we_s;
  logic [31:0]   rdata_s;

  logic [31:0] alu_w_q,  alu_w_d;
  logic [31:0] rdat_w_q, rdat_w_d;
  logic [31:0] pc4_w_q,  pc4_w_d;
  logic [1:0]  src_w_q,  src_w_d;
  logic [4:0]  rd_w_q,   rd_w_d;
  logic        rw_w_q,   rw_w_d;

  assign idx_s = ALUResultM[AW+1:2];

`ifdef MMIO_EN
  logic [31:0] mmio_data_q,  mmio_data_d;
  logic        mmio_valid_q, mmio_valid_d;
  logic        is_mmio_s;

  // MMIO decode uses the full address; the port never aliases into RAM.
  always_comb begin
    is_mmio_s    = (ALUResultM == MMIO_ADDR);
    ram_we_s     = MemWriteM & ~is_mmio_s;
    mmio_valid_d = MemWriteM & is_mmio_s;
    if (mmio_valid_d) begin
      mmio_data_d = WriteDataM;
    end else begin
      mmio_data_d = mmio_data_q;
    end
    if (is_mmio_s) begin
      rdata_s = mmio_data_q;
    end else begin
      rdata_s = ram_q[idx_s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mmio_data_q  <= 32'h0000_0000;
      mmio_valid_q <= 1'b0;
    end else begin
      mmio_data_q  <= mmio_data_d;
      mmio_valid_q <= mmio_valid_d;
    end
  end

  assign mmio_data  = mmio_data_q;
  assign mmio_valid = mmio_valid_q;
`else
  always_comb begin
    ram_we_s = MemWriteM;
    rdata_s  = ram_q[idx_s];
  end
`endif

  // RAM contents survive reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we_s) begin
      ram_q[idx_s] <= WriteDataM;
    end
  end

  always_comb begin
    alu_w_d  = ALUResultM;
    rdat_w_d = rdata_s;
    pc4_w_d  = PCPlus4M;
    src_w_d  = ResultSrcM;
    rd_w_d   = RdM;
    rw_w_d   = RegWriteM & (RdM != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_w_q  <= 32'h0000_0000;
      rdat_w_q <= 32'h0000_0000;
      pc4_w_q  <= 32'h0000_0000;
      src_w_q  <= 2'b00;
      rd_w_q   <= 5'd0;
      rw_w_q   <= 1'b0;
    end else begin
      alu_w_q  <= alu_w_d;
      rdat_w_q <= rdat_w_d;
      pc4_w_q  <= pc4_w_d;
      src_w_q  <= src_w_d;
      rd_w_q   <= rd_w_d;
      rw_w_q   <= rw_w_d;
    end
  end

  // Writeback result select; the reserved encoding returns zero.
  always_comb begin
    ResultW = 32'h0000_0000;
    case (src_w_q)
      2'b00:   ResultW = alu_w_q;
      2'b01:   ResultW = rdat_w_q;
      2'b10:   ResultW = pc4_w_q;
      default: ResultW = 32'h0000_0000;
    endcase
  end

  assign RegWriteW = rw_w_q;
  assign RdW       = rd_w_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table of directed vectors plus MMIO/alias sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic        RegWriteM, MemWriteM;
  logic [4:0]  RdM;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
`ifdef MMIO_EN
  logic [31:0] mmio_data;
  logic        mmio_valid;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.MEM_WORDS(64), .MMIO_ADDR(32'hFFFF_FFF0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .RdM(RdM), .MemWriteM(MemWriteM),
`ifdef MMIO_EN
    .mmio_data(mmio_data), .mmio_valid(mmio_valid),
`endif
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW)
  );

  typedef struct {
    logic        rst;
    logic [31:0] alu, wd, pc4;
    logic [1:0]  src;
    logic        rw;
    logic [4:0]  rd;
    logic        mw;
    logic        erw;
    logic [4:0]  erd;
    logic [31:0] eres;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc4, input logic [1:0] src, input logic rw,
                       input logic [4:0] rd, input logic mw);
    rst_n = rst; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
    ResultSrcM = src; RegWriteM = rw; RdM = rd; MemWriteM = mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string name, input logic erw, input logic [4:0] erd,
                         input logic [31:0] eres);
    check({name, ".rw"},  {31'd0, RegWriteW}, {31'd0, erw});
    check({name, ".rd"},  {27'd0, RdW},       {27'd0, erd});
    check({name, ".res"}, ResultW,            eres);
  endtask

  initial begin
    //          rst   alu            wd             pc4           src    rw    rd     mw    erw   erd    eres
    vecs[0]  = '{1'b0, 32'h0,        32'h0,         32'h0,        2'b00, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1]  = '{1'b1, 32'h20,       32'hA5A5_0001, 32'h0,        2'b00, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h20};
    vecs[2]  = '{1'b0, 32'h20,       32'h1111,      32'h0,        2'b00, 1'b1, 5'd5,  1'b1, 1'b0, 5'd0,  32'h0};
    vecs[3]  = '{1'b1, 32'h20,       32'h0,         32'h0,        2'b01, 1'b1, 5'd6,  1'b0, 1'b1, 5'd6,  32'hA5A5_0001};
    vecs[4]  = '{1'b1, 32'h1234,     32'h0,         32'h0,        2'b00, 1'b1, 5'd7,  1'b0, 1'b1, 5'd7,  32'h1234};
    vecs[5]  = '{1'b1, 32'h10,       32'hDEAD_BEEF, 32'h0,        2'b00, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h10};
    vecs[6]  = '{1'b1, 32'h10,       32'h0,         32'h0,        2'b01, 1'b1, 5'd3,  1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h110,      32'h0,         32'h0,        2'b01, 1'b1, 5'd4,  1'b0, 1'b1, 5'd4,  32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'h999,      32'h0,         32'h84,       2'b10, 1'b1, 5'd1,  1'b0, 1'b1, 5'd1,  32'h84};
    vecs[9]  = '{1'b1, 32'h999,      32'h0,         32'h84,       2'b10, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  32'h84};
    vecs[10] = '{1'b1, 32'h5,        32'h0,         32'h44,       2'b11, 1'b1, 5'd9,  1'b0, 1'b1, 5'd9,  32'h0};
    vecs[11] = '{1'b1, 32'h20,       32'h2222,      32'h0,        2'b01, 1'b1, 5'd10, 1'b1, 1'b1, 5'd10, 32'hA5A5_0001};
    vecs[12] = '{1'b1, 32'h20,       32'h0,         32'h0,        2'b01, 1'b1, 5'd11, 1'b0, 1'b1, 5'd11, 32'h2222};
    vecs[13] = '{1'b1, 32'hFFFF_0024, 32'h3333,     32'h0,        2'b00, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  32'hFFFF_0024};
    vecs[14] = '{1'b1, 32'h24,       32'h0,         32'h0,        2'b01, 1'b1, 5'd12, 1'b0, 1'b1, 5'd12, 32'h3333};

    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    step();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].alu, vecs[i].wd, vecs[i].pc4, vecs[i].src,
            vecs[i].rw, vecs[i].rd, vecs[i].mw);
      step();
      check_w($sformatf("vec%0d", i), vecs[i].erw, vecs[i].erd, vecs[i].eres);
    end

`ifdef MMIO_EN
    // Word 60 holds ordinary data; MMIO stores must not touch it.
    drive(1'b1, 32'hF0, 32'h77, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
    step();
    drive(1'b1, 32'hFFFF_FFF0, 32'h55, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
    step();
    check("mmio.valid1", {31'd0, mmio_valid}, 32'd1);
    check("mmio.data1",  mmio_data, 32'h55);
    drive(1'b1, 32'hF0, 32'h0, 32'h0, 2'b01, 1'b1, 5'd13, 1'b0);
    step();
    check("mmio.valid_drop", {31'd0, mmio_valid}, 32'd0);
    check_w("mmio.ram60", 1'b1, 5'd13, 32'h77);
    drive(1'b1, 32'hFFFF_FFF0, 32'h0, 32'h0, 2'b01, 1'b1, 5'd14, 1'b0);
    step();
    check_w("mmio.load", 1'b1, 5'd14, 32'h55);
    drive(1'b1, 32'hFFFF_FFF0, 32'h66, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
    step();
    check("mmio.b2b_v1", {31'd0, mmio_valid}, 32'd1);
    check("mmio.b2b_d1", mmio_data, 32'h66);
    drive(1'b1, 32'hFFFF_FFF0, 32'h67, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
    step();
    check("mmio.b2b_v2", {31'd0, mmio_valid}, 32'd1);
    check("mmio.b2b_d2", mmio_data, 32'h67);
    drive(1'b0, 32'hFFFF_FFF0, 32'h99, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
    step();
    check("mmio.rst_v", {31'd0, mmio_valid}, 32'd0);
    check("mmio.rst_d", mmio_data, 32'h0);
`else
    // Without MMIO the port address is plain RAM, aliased to word 60.
    drive(1'b1, 32'hFFFF_FFF0, 32'hCAFE, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
    step();
    drive(1'b1, 32'hF0, 32'h0, 32'h0, 2'b01, 1'b1, 5'd13, 1'b0);
    step();
    check_w("alias60", 1'b1, 5'd13, 32'hCAFE);
`endif

    drive(1'b1, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
